// File: rtl/memory_controller_pkg.sv
// Shared definitions for the byte-serial memory controller.
// Holds FSM state encodings, transfer-size constants and the IO address mask.
// Imported by memory_controller and mc_byte_shifter.
package memory_controller_pkg;

  localparam int WORD_RANGE = 32;

  localparam logic FALSE = 1'b0;
  localparam logic TRUE  = 1'b1;

  localparam logic [2:0] GOAL_BYTE = 3'd1;
  localparam logic [2:0] GOAL_HALF = 3'd2;
  localparam logic [2:0] GOAL_WORD = 3'd4;

  // Stores whose address matches all bits of this mask target the IO sink.
  localparam logic [WORD_RANGE-1:0] IO_BASE_MASK = 32'h0003_0000;

  typedef enum logic [1:0] {
    IDLE,
    LSB_READ,
    LSB_WRITE,
    IF_READ
  } state_t;

endpackage

// File: rtl/mc_byte_shifter.sv
// Byte lane selector/merger for the memory controller, purely combinational.
// byte_out picks lane idx of word_in (store path); word_out is word_in with
// lane idx replaced by byte_in (load assembly path).
module mc_byte_shifter
  import memory_controller_pkg::*;
(
  input  logic [1:0]            idx,
  input  logic [WORD_RANGE-1:0] word_in,
  input  logic [7:0]            byte_in,
  output logic [7:0]            byte_out,
  output logic [WORD_RANGE-1:0] word_out
);

  // Select and replace one little-endian byte lane.
  always_comb begin
    word_out                    = word_in;
    word_out[{idx, 3'b000} +: 8] = byte_in;
    byte_out                    = word_in[{idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/memory_controller.sv
// Arbitrates LSB and fetch requests onto one 8-bit synchronous RAM port.
// Loads: ready at R+n+2, stores: R+n+1, fetch: R+6; requests queue one deep.
// Optional IO_STALL_EN macro: stores to the IO region wait on io_buffer_full_in.
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rob_rollback_in,
  input  logic                  lsb_request_in,
  input  logic                  lsb_rw_signal_in,
  input  logic [WORD_RANGE-1:0] lsb_address_in,
  input  logic [2:0]            lsb_goal_in,
  input  logic [WORD_RANGE-1:0] lsb_data_in,
  output logic                  lsb_ready_out,
  output logic [WORD_RANGE-1:0] lsb_data_out,
  input  logic                  if_request_in,
  input  logic [WORD_RANGE-1:0] if_address_in,
  output logic                  if_ready_out,
  output logic [WORD_RANGE-1:0] if_inst_out,
  input  logic [7:0]            ram_data_in,
  output logic [7:0]            ram_data_out,
  output logic [WORD_RANGE-1:0] ram_address_out,
  output logic                  ram_rw_out,
  input  logic                  io_buffer_full_in
);

  state_t                state, state_n;
  logic [2:0]            cnt, cnt_n;
  logic [WORD_RANGE-1:0] cur_addr, cur_data, asm_word;
  logic [2:0]            cur_goal;

  logic                  lsb_pend, lsb_pend_rw, if_pend;
  logic [WORD_RANGE-1:0] lsb_pend_addr, lsb_pend_data, if_pend_addr;
  logic [2:0]            lsb_pend_goal;

  logic                  sel_rw;
  logic [WORD_RANGE-1:0] sel_addr, sel_data, sel_if_addr;
  logic [2:0]            sel_goal;

  logic start_lsb, start_if, capture, lsb_done, if_done, stall;
  logic lsb_go, if_go;

  logic [1:0]            sh_idx;
  logic [WORD_RANGE-1:0] sh_word, merged;
  logic [7:0]            wr_byte;

  // A latched request takes precedence over a fresh pulse of the same source.
  assign lsb_go      = lsb_pend | lsb_request_in;
  assign if_go       = if_pend | if_request_in;
  assign sel_rw      = lsb_pend ? lsb_pend_rw   : lsb_rw_signal_in;
  assign sel_addr    = lsb_pend ? lsb_pend_addr : lsb_address_in;
  assign sel_goal    = lsb_pend ? lsb_pend_goal : lsb_goal_in;
  assign sel_data    = lsb_pend ? lsb_pend_data : lsb_data_in;
  assign sel_if_addr = if_pend  ? if_pend_addr  : if_address_in;

`ifdef IO_STALL_EN
  assign stall = (state == LSB_WRITE) && io_buffer_full_in &&
                 ((cur_addr & IO_BASE_MASK) == IO_BASE_MASK);
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full_in;
  assign stall          = FALSE;
`endif

  // Stores emit lane cnt; loads merge the byte addressed one cycle earlier.
  assign sh_idx  = (state == LSB_WRITE) ? cnt[1:0] : (cnt[1:0] - 2'd1);
  assign sh_word = (state == LSB_WRITE) ? cur_data : asm_word;

  mc_byte_shifter u_shifter (
    .idx      (sh_idx),
    .word_in  (sh_word),
    .byte_in  (ram_data_in),
    .byte_out (wr_byte),
    .word_out (merged)
  );

  // RAM port is decoded from state so IDLE and reset drive zeros directly.
  assign ram_rw_out      = (state == LSB_WRITE) && !stall;
  assign ram_data_out    = (state == LSB_WRITE) ? wr_byte : 8'h00;
  assign ram_address_out = (state != IDLE && cnt < cur_goal) ?
                           cur_addr + {29'b0, cnt} : '0;

  // Next-state: arbitration in IDLE, byte sequencing, rollback handling.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    start_lsb = FALSE;
    start_if  = FALSE;
    capture   = FALSE;
    lsb_done  = FALSE;
    if_done   = FALSE;
    case (state)
      IDLE: begin
        if (!rob_rollback_in) begin
          if (lsb_go) begin
            start_lsb = TRUE;
            state_n   = sel_rw ? LSB_WRITE : LSB_READ;
          end else if (if_go) begin
            start_if = TRUE;
            state_n  = IF_READ;
          end
        end
      end
      LSB_READ, IF_READ: begin
        if (rob_rollback_in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          capture = (cnt != 3'd0);
          if (cnt == cur_goal) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == LSB_READ) lsb_done = TRUE;
            else                   if_done  = TRUE;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      LSB_WRITE: begin
        // Stores are never squashed by rollback.
        if (!stall) begin
          if (cnt == cur_goal - 3'd1) begin
            state_n  = IDLE;
            cnt_n    = '0;
            lsb_done = TRUE;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State and byte counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Datapath: transfer operands, load assembly, results, request latches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_addr      <= '0;
      cur_data      <= '0;
      cur_goal      <= '0;
      asm_word      <= '0;
      lsb_ready_out <= FALSE;
      if_ready_out  <= FALSE;
      lsb_data_out  <= '0;
      if_inst_out   <= '0;
      lsb_pend      <= FALSE;
      lsb_pend_rw   <= FALSE;
      lsb_pend_addr <= '0;
      lsb_pend_goal <= '0;
      lsb_pend_data <= '0;
      if_pend       <= FALSE;
      if_pend_addr  <= '0;
    end else begin
      lsb_ready_out <= lsb_done;
      if_ready_out  <= if_done;
      if (capture) asm_word <= merged;
      if (lsb_done && state == LSB_READ) lsb_data_out <= merged;
      if (if_done) if_inst_out <= merged;
      if (start_lsb) begin
        cur_addr <= sel_addr;
        cur_goal <= sel_goal;
        cur_data <= sel_data;
        asm_word <= '0;
      end else if (start_if) begin
        cur_addr <= sel_if_addr;
        cur_goal <= GOAL_WORD;
        asm_word <= '0;
      end
      if (rob_rollback_in) begin
        lsb_pend <= FALSE;
        if_pend  <= FALSE;
      end else begin
        if (lsb_request_in) begin
          lsb_pend_rw   <= lsb_rw_signal_in;
          lsb_pend_addr <= lsb_address_in;
          lsb_pend_goal <= lsb_goal_in;
          lsb_pend_data <= lsb_data_in;
        end
        if (if_request_in) if_pend_addr <= if_address_in;
        lsb_pend <= start_lsb ? (lsb_pend & lsb_request_in) : (lsb_pend | lsb_request_in);
        if_pend  <= start_if  ? (if_pend & if_request_in)   : (if_pend | if_request_in);
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: directed scenarios plus random
// loads/stores/fetches checked against a byte-array RAM and latency rules.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rob_rollback_in = 1'b0;
  logic        lsb_request_in = 1'b0;
  logic        lsb_rw_signal_in = 1'b0;
  logic [31:0] lsb_address_in = '0;
  logic [2:0]  lsb_goal_in = '0;
  logic [31:0] lsb_data_in = '0;
  logic        lsb_ready_out;
  logic [31:0] lsb_data_out;
  logic        if_request_in = 1'b0;
  logic [31:0] if_address_in = '0;
  logic        if_ready_out;
  logic [31:0] if_inst_out;
  logic [7:0]  ram_data_in = '0;
  logic [7:0]  ram_data_out;
  logic [31:0] ram_address_out;
  logic        ram_rw_out;
  logic        io_buffer_full_in = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wlog[$];

  logic [7:0] mem [logic [31:0]];

  memory_controller dut (
    .clk               (clk),
    .rst               (rst),
    .rob_rollback_in   (rob_rollback_in),
    .lsb_request_in    (lsb_request_in),
    .lsb_rw_signal_in  (lsb_rw_signal_in),
    .lsb_address_in    (lsb_address_in),
    .lsb_goal_in       (lsb_goal_in),
    .lsb_data_in       (lsb_data_in),
    .lsb_ready_out     (lsb_ready_out),
    .lsb_data_out      (lsb_data_out),
    .if_request_in     (if_request_in),
    .if_address_in     (if_address_in),
    .if_ready_out      (if_ready_out),
    .if_inst_out       (if_inst_out),
    .ram_data_in       (ram_data_in),
    .ram_data_out      (ram_data_out),
    .ram_address_out   (ram_address_out),
    .ram_rw_out        (ram_rw_out),
    .io_buffer_full_in (io_buffer_full_in)
  );

  always #5 clk = ~clk;

  // Unwritten locations hold an address-derived pattern.
  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous RAM: read data valid the cycle after its address; writes logged.
  always @(posedge clk) begin
    ram_data_in <= rd_byte(ram_address_out);
    if (ram_rw_out === 1'b1) begin
      mem[ram_address_out] = ram_data_out;
      wlog.push_back('{cyc, ram_address_out, ram_data_out});
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One LSB transaction in a fixed 12-cycle window; rb_off/io window are cycle offsets from R.
  task automatic lsb_txn(input logic rw, input logic [31:0] a, input logic [2:0] n,
                         input logic [31:0] d, input int rb_off, input int io_lo,
                         input int io_hi, input int exp_lat, input string tag);
    logic [31:0] exp_d;
    logic [31:0] dat;
    int got, pulses, r;
    exp_d = '0;
    if (!rw) for (int k = 0; k < int'(n); k++) exp_d[8*k +: 8] = rd_byte(a + 32'(k));
    @(negedge clk);
    r = cyc;
    lsb_request_in = 1'b1; lsb_rw_signal_in = rw; lsb_address_in = a;
    lsb_goal_in = n; lsb_data_in = d;
    wlog.delete();
    got = -1; pulses = 0; dat = '0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      lsb_request_in    = 1'b0;
      rob_rollback_in   = (t == rb_off);
      io_buffer_full_in = (t >= io_lo && t <= io_hi);
      if (lsb_ready_out) begin
        pulses++;
        if (got < 0) begin got = t; dat = lsb_data_out; end
      end
    end
    rob_rollback_in = 1'b0; io_buffer_full_in = 1'b0;
    check({tag, " latency"}, got, exp_lat);
    check({tag, " ready pulses"}, pulses, 1);
    if (!rw) begin
      check({tag, " load data"}, dat, exp_d);
      check({tag, " no writes"}, wlog.size(), 0);
    end else begin
      check({tag, " write count"}, wlog.size(), 32'(n));
      for (int k = 0; k < int'(n) && k < wlog.size(); k++) begin
        check({tag, " write cycle"}, wlog[k].c, r + exp_lat - int'(n) + k);
        check({tag, " write addr"}, wlog[k].a, a + 32'(k));
        check({tag, " write byte"}, wlog[k].d, d[8*k +: 8]);
      end
    end
  endtask

  // Fetch; rb_off > 0 squashes it, checking idle drive and absence of ready.
  task automatic if_txn(input logic [31:0] a, input int rb_off, input string tag);
    logic [31:0] exp_d;
    logic [31:0] dat;
    int got, pulses;
    for (int k = 0; k < 4; k++) exp_d[8*k +: 8] = rd_byte(a + 32'(k));
    @(negedge clk);
    if_request_in = 1'b1; if_address_in = a;
    got = -1; pulses = 0; dat = '0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if_request_in   = 1'b0;
      rob_rollback_in = (t == rb_off);
      if (if_ready_out) begin
        pulses++;
        if (got < 0) begin got = t; dat = if_inst_out; end
      end
      if (rb_off > 0 && t == rb_off + 1) begin
        check({tag, " idle addr after rollback"}, ram_address_out, 32'h0);
        check({tag, " idle rw after rollback"}, ram_rw_out, 1'b0);
      end
    end
    rob_rollback_in = 1'b0;
    if (rb_off > 0) begin
      check({tag, " squashed ready pulses"}, pulses, 0);
    end else begin
      check({tag, " latency"}, got, 6);
      check({tag, " ready pulses"}, pulses, 1);
      check({tag, " inst"}, dat, exp_d);
    end
  endtask

  initial begin
    logic [31:0] a, d, exp_l, exp_i, addr_after;
    logic [2:0]  n;
    logic        rw;
    int lsb_t, if_t, pulses, io_lat;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset lsb_ready", lsb_ready_out, 1'b0);
    check("reset if_ready", if_ready_out, 1'b0);
    check("reset lsb_data", lsb_data_out, 32'h0);
    check("reset if_inst", if_inst_out, 32'h0);
    check("reset ram_addr", ram_address_out, 32'h0);
    check("reset ram_data", ram_data_out, 8'h00);
    check("reset ram_rw", ram_rw_out, 1'b0);
    rst = 1'b1;

    // LW 0x100
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    lsb_txn(1'b0, 32'h100, 3'd4, 32'h0, -1, 99, 0, 6, "LW 0x100");
    check("LW 0x100 value", lsb_data_out, 32'h4433_2211);
    // LB zero-fill
    lsb_txn(1'b0, 32'h101, 3'd1, 32'h0, -1, 99, 0, 3, "LB 0x101");
    check("LB 0x101 value", lsb_data_out, 32'h0000_0022);
    // SH at 0x2
    lsb_txn(1'b1, 32'h2, 3'd2, 32'hDEAD_BEEF, -1, 99, 0, 3, "SH 0x2");
    check("SH mem 0x2", rd_byte(32'h2), 8'hEF);
    check("SH mem 0x3", rd_byte(32'h3), 8'hBE);
    check("SH mem 0x4 untouched", mem.exists(32'h4), 1'b0);

    // Simultaneous LSB load and fetch: LSB first, fetch right after.
    exp_l = {rd_byte(32'h203), rd_byte(32'h202), rd_byte(32'h201), rd_byte(32'h200)};
    exp_i = {rd_byte(32'h403), rd_byte(32'h402), rd_byte(32'h401), rd_byte(32'h400)};
    @(negedge clk);
    lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h200; lsb_goal_in = 3'd4;
    if_request_in = 1'b1; if_address_in = 32'h400;
    lsb_t = -1; if_t = -1; addr_after = 32'hFFFF_FFFF;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      lsb_request_in = 1'b0; if_request_in = 1'b0;
      if (lsb_t > 0 && t == lsb_t + 1) addr_after = ram_address_out;
      if (lsb_ready_out && lsb_t < 0) begin lsb_t = t; d = lsb_data_out; end
      if (if_ready_out && if_t < 0) begin if_t = t; a = if_inst_out; end
    end
    check("dual lsb latency", lsb_t, 6);
    check("dual lsb data", d, exp_l);
    check("dual if addr after lsb ready", addr_after, 32'h400);
    check("dual if latency", if_t, 12);
    check("dual if inst", a, exp_i);

    // Rollback during fetch at cnt 2, then a clean fetch.
    if_txn(32'h500, 3, "IF rollback");
    if_txn(32'h504, 0, "IF after rollback");

    // Rollback during SW: store completes.
    lsb_txn(1'b1, 32'h600, 3'd4, 32'hCAFE_F00D, 2, 99, 0, 5, "SW rollback");

    // IO-region store with sink back-pressure.
`ifdef IO_STALL_EN
    io_lat = 5;
`else
    io_lat = 2;
`endif
    lsb_txn(1'b1, 32'h0003_0000, 3'd1, 32'h0000_00A5, -1, 1, 3, io_lat, "SB IO");

    // Random traffic
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        if_txn($urandom & 32'h0000_FFFF, 0, "rand IF");
      end else begin
        rw = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       n = 3'd1;
          1:       n = 3'd2;
          default: n = 3'd4;
        endcase
        a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                        : ($urandom & 32'h0000_FFFF);
        d = $urandom;
        lsb_txn(rw, a, n, d, -1, 99, 0, rw ? int'(n) + 1 : int'(n) + 2, "rand LSB");
      end
    end

    // Reset mid-LW: outputs clear, no ready for the aborted load.
    @(negedge clk);
    lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0; lsb_address_in = 32'h700; lsb_goal_in = 3'd4;
    pulses = 0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      lsb_request_in = 1'b0;
      if (lsb_ready_out) pulses++;
      if (t == 2) rst = 1'b0;
      if (t == 3) begin
        check("mid reset lsb_ready", lsb_ready_out, 1'b0);
        check("mid reset lsb_data", lsb_data_out, 32'h0);
        check("mid reset ram_addr", ram_address_out, 32'h0);
        check("mid reset ram_rw", ram_rw_out, 1'b0);
        check("mid reset if_inst", if_inst_out, 32'h0);
        rst = 1'b1;
      end
    end
    check("mid reset no ready", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
